// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential execute-stage ALU: operation codes, FSM states, helpers.
// Build option ALU_BARREL_SHIFT_EN selects one-cycle barrel shifts over iterative shifts.
package alu_seq_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_XOR = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_EQ  = 4'b1000,
        ALU_SLT = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the datapath and alu_seq_exec.
// master = datapath side, slave = ALU side.
interface alu_seq_exec_if
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic [ALU_OP_W-1:0]   Operation;
    logic                  InValid;
    logic                  InReady;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;
    logic                  OutValid;
    logic                  OutReady;

    modport master (
        output SrcA, SrcB, Operation, InValid, OutReady,
        input  InReady, ALUResult, Zero, OutValid
    );

    modport slave (
        input  SrcA, SrcB, Operation, InValid, OutReady,
        output InReady, ALUResult, Zero, OutValid
    );

endinterface

// File: rtl/alu_seq_exec_comb_core.sv
// alu_comb_core: purely combinational evaluator for single-cycle ops; with ALU_BARREL_SHIFT_EN
// it also evaluates shifts, otherwise shift codes return 0 and the caller iterates them.
module alu_comb_core
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  alu_op_e               op_i,
    output logic [DATA_WIDTH-1:0] result_o
);

`ifdef ALU_BARREL_SHIFT_EN
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
    logic [SHAMT_WIDTH-1:0] shamt;
    assign shamt = b_i[SHAMT_WIDTH-1:0];
`endif

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_ADD: result_o = a_i + b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_EQ:  result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i == b_i)};
            ALU_SLT: result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL: result_o = a_i << shamt;
            ALU_SRL: result_o = a_i >> shamt;
            ALU_SRA: result_o = $signed(a_i) >>> shamt;
`endif
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with valid/ready on both sides; shifts take one cycle per bit unless
// ALU_BARREL_SHIFT_EN is defined, in which case every operation has latency 1.
module alu_seq_exec
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    alu_seq_exec_if.slave bus
);

    alu_state_e            state_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  out_vld_q;

    alu_op_e               op_in;
    logic                  accept;
    logic [DATA_WIDTH-1:0] core_res;
    logic [DATA_WIDTH-1:0] idle_res_d;

    assign op_in       = alu_op_e'(bus.Operation);
    // Ready is decoded from state so it is already high on the first cycle out of reset.
    assign bus.InReady = (state_q == IDLE) && !reset;
    assign accept      = bus.InValid && bus.InReady;

    alu_comb_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .a_i      (bus.SrcA),
        .b_i      (bus.SrcB),
        .op_i     (op_in),
        .result_o (core_res)
    );

`ifndef ALU_BARREL_SHIFT_EN
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic [SHAMT_WIDTH-1:0] sh_amt;
    logic [DATA_WIDTH-1:0]  work_q;
    logic [DATA_WIDTH-1:0]  work_d;
    alu_op_e                sh_op_q;
    logic                   start_shift;

    assign sh_amt      = bus.SrcB[SHAMT_WIDTH-1:0];
    assign start_shift = is_shift_op(op_in) && (sh_amt != '0);
    // A zero-amount shift falls through the IDLE path and returns SrcA unchanged.
    assign idle_res_d  = is_shift_op(op_in) ? bus.SrcA : core_res;

    always_comb begin
        work_d = work_q;
        case (sh_op_q)
            ALU_SLL: work_d = {work_q[DATA_WIDTH-2:0], 1'b0};
            ALU_SRL: work_d = {1'b0, work_q[DATA_WIDTH-1:1]};
            default: work_d = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
        endcase
    end
`else
    assign idle_res_d = core_res;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            out_vld_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            cnt_q     <= '0;
            work_q    <= '0;
            sh_op_q   <= ALU_SLL;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
                        if (start_shift) begin
                            work_q  <= bus.SrcA;
                            cnt_q   <= sh_amt;
                            sh_op_q <= op_in;
                            state_q <= SHIFT;
                        end else begin
                            result_q  <= idle_res_d;
                            zero_q    <= (idle_res_d == '0);
                            out_vld_q <= 1'b1;
                            state_q   <= DONE;
                        end
`else
                        result_q  <= idle_res_d;
                        zero_q    <= (idle_res_d == '0);
                        out_vld_q <= 1'b1;
                        state_q   <= DONE;
`endif
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - SHAMT_WIDTH'(1);
                    if (cnt_q == SHAMT_WIDTH'(1)) begin
                        result_q  <= work_d;
                        zero_q    <= (work_d == '0);
                        out_vld_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (bus.OutReady) begin
                        out_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_vld_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;
    assign bus.OutValid  = out_vld_q;

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller, plus two operands.
- Returns ALUResult and Zero to the datapath.
- Shifts are iterative by default, one bit per cycle. All other operations complete in one cycle.
- A valid/ready handshake on both sides lets the pipeline stall while a shift is in progress.

Parameters:
- DATA_WIDTH, 32, operand and result width. Must be a power of 2 and at least 8.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount width. Derived; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- SrcA  in  DATA_WIDTH  operand A.
- SrcB  in  DATA_WIDTH  operand B. For shifts, SrcB[SHAMT_WIDTH-1:0] is the shift amount.
- Operation  in  4  ALU operation code.
- InValid  in  1  request valid.
- InReady  out  1  block can accept a request.
- ALUResult  out  DATA_WIDTH  result.
- Zero  out  1  ALUResult == 0.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts the result.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Operation codes:
  - 0000 AND
  - 0001 XOR
  - 0010 ADD
  - 0011 OR
  - 0100 SLL
  - 0101 SRL
  - 0110 SUB
  - 0111 SRA
  - 1000 EQ: result 1 if SrcA==SrcB, else 0
  - 1101 SLT: signed compare, result 1 or 0
  - Every other code gives result 0.
- Arithmetic: ADD and SUB wrap modulo 2^DATA_WIDTH. No carry or overflow outputs. SRA replicates the MSB of SrcA.
- Reset values: state IDLE, InReady=0 during reset and 1 after reset, OutValid=0, ALUResult=0, Zero=0 (ALUResult and Zero are registered and cleared). Internal shift counter = 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE:
    - InReady=1.
    - On InValid&&InReady: latch SrcA, SrcB and Operation.
    - Non-shift op: compute, register the result, go to DONE. OutValid rises on the cycle after acceptance (latency 1).
    - Shift op with amount 0: result = SrcA, go to DONE (latency 1).
    - Shift op with amount N>0: load the counter with N, go to SHIFT.
  - SHIFT:
    - InReady=0.
    - Each cycle: shift the working register by 1 in the selected direction and decrement the counter.
    - When the counter reaches 1, perform the last step and go to DONE. OutValid rises N+1 cycles after acceptance.
  - DONE:
    - OutValid=1. ALUResult and Zero are held stable.
    - OutReady=1: go to IDLE next cycle. A new request can be accepted no earlier than the following cycle, so minimum throughput is one operation per 2 cycles.
    - OutReady=0: hold indefinitely. InValid is ignored.
- Handshake and boundaries:
  - Inputs are sampled only on the acceptance cycle. Changes to SrcA, SrcB or Operation afterwards do not affect the operation in flight.
  - Shift amount is SrcB[SHAMT_WIDTH-1:0]. Upper bits of SrcB are ignored, so 32 acts as 0 and 33 acts as 1 at DATA_WIDTH=32.
  - Zero is computed from the final registered result and is valid only while OutValid=1.
  - Reset asserted in any state (including mid-shift or in DONE with OutReady=0) returns the block to IDLE next cycle. The in-flight operation is discarded and OutValid=0.
  - InValid held high in IDLE with a constant request is accepted exactly once per handshake.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined:
  - Shifts are computed combinationally in IDLE with a barrel shifter and go directly to DONE.
  - Every operation has latency 1. The SHIFT state and counter are not instantiated.
- Undefined: iterative shifting as described in Behaviour.
- Results are bit-identical in both configurations; only latency differs.

Decomposition:
- Package alu_seq_pkg holds:
  - typedef enum logic [3:0] alu_op_e with the codes listed in Behaviour;
  - typedef enum logic [1:0] alu_state_e {IDLE, SHIFT, DONE};
  - localparam ALU_OP_W=4.
- One sub-module, alu_comb_core: a purely combinational evaluator for all non-iterative ops (and for barrel shifts when ALU_BARREL_SHIFT_EN is defined). The top level holds the FSM, counter and output registers.

Test Plan:
- Reset with InValid=1 held for 3 cycles, then released -> OutValid=0, ALUResult=0, InReady=1 on the first cycle after reset deasserts, and nothing is accepted while reset is high.
- ADD 0xFFFFFFFF + 0x00000002 (op 0010), OutReady=1 -> one cycle later ALUResult=0x00000001, Zero=0. SUB 5-5 (op 0110) -> ALUResult=0, Zero=1.
- SRA SrcA=0x80000000, SrcB=4 (op 0111) -> OutValid after 5 cycles (iterative) or 1 cycle (ALU_BARREL_SHIFT_EN), ALUResult=0xF8000000. SLL with SrcB=0x20 -> amount 0, ALUResult=SrcA, latency 1.
- SLT SrcA=0xFFFFFFFF, SrcB=1 (op 1101) -> ALUResult=1. EQ 7,7 (op 1000) -> ALUResult=1. Illegal op 1111 -> ALUResult=0, Zero=1.
- Backpressure: complete an XOR with OutReady=0 for 4 cycles while driving a new InValid and changing SrcA -> OutValid stays 1, ALUResult stays stable, InReady=0, no new acceptance. Raising OutReady -> IDLE, then the pending request is accepted.
- Start SRL by 31, assert reset on the 10th SHIFT cycle -> next cycle state IDLE, OutValid=0. The next request (AND 0xF0F0 & 0xFF00) returns 0xF000.
